// File: rtl/wb_regfile.sv
// 16x16 register file with pending bits for late results arriving through a fill port.
// Reads are combinational and bypass same-cycle write-backs, fills and pending-marks.
module wb_regfile (
   input  logic        clock,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [3:0]  dst,
   input  logic [15:0] wb_data,
   input  logic        wb_datav,
   input  logic        fill_valid,
   input  logic [3:0]  fill_dst,
   input  logic [15:0] fill_data,
   output logic        fill_ready,
   input  logic [3:0]  rd_adrs_a,
   input  logic [3:0]  rd_adrs_b,
   output logic [15:0] rd_data_a,
   output logic [15:0] rd_data_b,
   output logic        rd_pend_a,
   output logic        rd_pend_b,
   output logic        stall,
   output logic [15:0] commit_cnt
);

   logic [15:0] r_regs [16];
   logic [15:0] r_pend;
   logic [15:0] r_cnt;

   logic        w_wr_data;
   logic        w_wr_cnt;
   logic        w_mark;
   logic        w_fill_eff;
   logic [1:0]  w_inc;
   logic [16:0] w_sum;
   logic [3:0]  w_adrs  [2];
   logic [15:0] w_rdata [2];
   logic        w_rpend [2];

   assign fill_ready = ~reset & ~(wr_en & wb_datav);
   assign w_wr_data  = wr_en & wb_datav & ~reset;
   assign w_wr_cnt   = w_wr_data & (dst != 4'd0);
   assign w_mark     = wr_en & ~wb_datav & ~reset & (dst != 4'd0);
   // r_pend[0] never leaves 0, so fills to R0 are always dropped here
   assign w_fill_eff = fill_valid & fill_ready & r_pend[fill_dst];
   assign w_inc      = {1'b0, w_wr_cnt} + {1'b0, w_fill_eff};
   assign w_sum      = {1'b0, r_cnt} + 17'(w_inc);

   assign w_adrs[0] = rd_adrs_a;
   assign w_adrs[1] = rd_adrs_b;

   // Bypass priority: data write, then fill, with a same-cycle mark forcing pend back to 1
   always_comb begin
      for (int unsigned p = 0; p < 2; p++) begin
         w_rdata[p] = r_regs[w_adrs[p]];
         w_rpend[p] = r_pend[w_adrs[p]];
         if (w_adrs[p] == 4'd0) begin
            w_rdata[p] = '0;
            w_rpend[p] = 1'b0;
         end else if (w_wr_data && (dst == w_adrs[p])) begin
            w_rdata[p] = wb_data;
            w_rpend[p] = 1'b0;
         end else begin
            if (w_fill_eff && (fill_dst == w_adrs[p])) begin
               w_rdata[p] = fill_data;
               w_rpend[p] = 1'b0;
            end
            if (w_mark && (dst == w_adrs[p]))
               w_rpend[p] = 1'b1;
         end
      end
   end

   assign rd_data_a  = w_rdata[0];
   assign rd_data_b  = w_rdata[1];
   assign rd_pend_a  = w_rpend[0];
   assign rd_pend_b  = w_rpend[1];
   assign stall      = w_rpend[0] | w_rpend[1];
   assign commit_cnt = r_cnt;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_regs <= '{default: '0};
         r_pend <= '0;
         r_cnt  <= '0;
      end else begin
         for (int unsigned i = 1; i < 16; i++) begin
            if (w_wr_data && (dst == 4'(i))) begin
               r_regs[i] <= wb_data;
               r_pend[i] <= 1'b0;
            end else begin
               if (w_fill_eff && (fill_dst == 4'(i))) begin
                  r_regs[i] <= fill_data;
                  r_pend[i] <= 1'b0;
               end
               if (w_mark && (dst == 4'(i)))
                  r_pend[i] <= 1'b1;
            end
         end
         r_cnt <= w_sum[16] ? '1 : w_sum[15:0];
      end
   end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: bypass, pending/fill, priority, drops, saturation, reset.
module tb_wb_regfile;

   logic        clock = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [3:0]  dst;
   logic [15:0] wb_data;
   logic        wb_datav;
   logic        fill_valid;
   logic [3:0]  fill_dst;
   logic [15:0] fill_data;
   logic        fill_ready;
   logic [3:0]  rd_adrs_a;
   logic [3:0]  rd_adrs_b;
   logic [15:0] rd_data_a;
   logic [15:0] rd_data_b;
   logic        rd_pend_a;
   logic        rd_pend_b;
   logic        stall;
   logic [15:0] commit_cnt;

   int checks = 0;
   int passed = 0;

   wb_regfile dut (
      .clock(clock), .reset(reset), .wr_en(wr_en), .dst(dst), .wb_data(wb_data),
      .wb_datav(wb_datav), .fill_valid(fill_valid), .fill_dst(fill_dst),
      .fill_data(fill_data), .fill_ready(fill_ready), .rd_adrs_a(rd_adrs_a),
      .rd_adrs_b(rd_adrs_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
      .rd_pend_a(rd_pend_a), .rd_pend_b(rd_pend_b), .stall(stall),
      .commit_cnt(commit_cnt)
   );

   always #5 clock = ~clock;

   task automatic idle();
      reset = 1'b0; wr_en = 1'b0; dst = 4'd0; wb_data = 16'h0; wb_datav = 1'b0;
      fill_valid = 1'b0; fill_dst = 4'd0; fill_data = 16'h0;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1; rd_adrs_a = 4'd3; rd_adrs_b = 4'd0;
      #1;
      checks++; if (fill_ready !== 1'b0) $display("FAIL rst_fill_ready: got %b exp 0", fill_ready); else passed++;
      step(); step();
      idle();
      #1;
      checks++; if (commit_cnt !== 16'h0) $display("FAIL rst_cnt: got %h exp 0000", commit_cnt); else passed++;
      checks++; if (rd_data_a !== 16'h0) $display("FAIL rst_data: got %h exp 0000", rd_data_a); else passed++;
      checks++; if (stall !== 1'b0) $display("FAIL rst_stall: got %b exp 0", stall); else passed++;
   endtask

   task automatic test_bypass_write();
      wr_en = 1'b1; dst = 4'd3; wb_data = 16'h1234; wb_datav = 1'b1; rd_adrs_a = 4'd3;
      #1;
      checks++; if (rd_data_a !== 16'h1234) $display("FAIL byp_data: got %h exp 1234", rd_data_a); else passed++;
      checks++; if (rd_pend_a !== 1'b0) $display("FAIL byp_pend: got %b exp 0", rd_pend_a); else passed++;
      checks++; if (fill_ready !== 1'b0) $display("FAIL byp_fill_ready: got %b exp 0", fill_ready); else passed++;
      step();
      idle();
      #1;
      checks++; if (rd_data_a !== 16'h1234) $display("FAIL stored_data: got %h exp 1234", rd_data_a); else passed++;
      checks++; if (commit_cnt !== 16'd1) $display("FAIL cnt_after_write: got %h exp 0001", commit_cnt); else passed++;
   endtask

   task automatic test_pend_fill();
      wr_en = 1'b1; dst = 4'd5; wb_datav = 1'b0; wb_data = 16'h9999; rd_adrs_b = 4'd5;
      #1;
      checks++; if (rd_pend_b !== 1'b1) $display("FAIL mark_byp_pend: got %b exp 1", rd_pend_b); else passed++;
      step();
      idle();
      #1;
      checks++; if (rd_pend_b !== 1'b1) $display("FAIL mark_pend: got %b exp 1", rd_pend_b); else passed++;
      checks++; if (stall !== 1'b1) $display("FAIL mark_stall: got %b exp 1", stall); else passed++;
      checks++; if (commit_cnt !== 16'd1) $display("FAIL mark_cnt: got %h exp 0001", commit_cnt); else passed++;
      fill_valid = 1'b1; fill_dst = 4'd5; fill_data = 16'hBEEF;
      #1;
      checks++; if (fill_ready !== 1'b1) $display("FAIL fill_ready: got %b exp 1", fill_ready); else passed++;
      checks++; if (rd_data_b !== 16'hBEEF) $display("FAIL fill_byp_data: got %h exp beef", rd_data_b); else passed++;
      checks++; if (rd_pend_b !== 1'b0) $display("FAIL fill_byp_pend: got %b exp 0", rd_pend_b); else passed++;
      checks++; if (stall !== 1'b0) $display("FAIL fill_byp_stall: got %b exp 0", stall); else passed++;
      step();
      idle();
      #1;
      checks++; if (rd_data_b !== 16'hBEEF) $display("FAIL fill_stored: got %h exp beef", rd_data_b); else passed++;
      checks++; if (commit_cnt !== 16'd2) $display("FAIL fill_cnt: got %h exp 0002", commit_cnt); else passed++;
   endtask

   task automatic test_wb_priority();
      wr_en = 1'b1; dst = 4'd5; wb_datav = 1'b0;
      step();
      wr_en = 1'b1; dst = 4'd7; wb_data = 16'h7777; wb_datav = 1'b1;
      fill_valid = 1'b1; fill_dst = 4'd5; fill_data = 16'hCAFE;
      rd_adrs_a = 4'd7; rd_adrs_b = 4'd5;
      #1;
      checks++; if (fill_ready !== 1'b0) $display("FAIL prio_fill_ready: got %b exp 0", fill_ready); else passed++;
      checks++; if (rd_data_a !== 16'h7777) $display("FAIL prio_wr_byp: got %h exp 7777", rd_data_a); else passed++;
      checks++; if (rd_pend_b !== 1'b1) $display("FAIL prio_still_pend: got %b exp 1", rd_pend_b); else passed++;
      step();
      wr_en = 1'b0; wb_datav = 1'b0;
      #1;
      checks++; if (fill_ready !== 1'b1) $display("FAIL held_fill_ready: got %b exp 1", fill_ready); else passed++;
      checks++; if (rd_data_b !== 16'hCAFE) $display("FAIL held_fill_byp: got %h exp cafe", rd_data_b); else passed++;
      checks++; if (commit_cnt !== 16'd3) $display("FAIL prio_cnt_mid: got %h exp 0003", commit_cnt); else passed++;
      step();
      idle();
      #1;
      checks++; if (rd_data_a !== 16'h7777) $display("FAIL r7_stored: got %h exp 7777", rd_data_a); else passed++;
      checks++; if (rd_data_b !== 16'hCAFE) $display("FAIL r5_stored: got %h exp cafe", rd_data_b); else passed++;
      checks++; if (rd_pend_b !== 1'b0) $display("FAIL r5_pend_clear: got %b exp 0", rd_pend_b); else passed++;
      checks++; if (commit_cnt !== 16'd4) $display("FAIL prio_cnt: got %h exp 0004", commit_cnt); else passed++;
   endtask

   task automatic test_drops();
      fill_valid = 1'b1; fill_dst = 4'd9; fill_data = 16'h5555; rd_adrs_a = 4'd9;
      #1;
      checks++; if (fill_ready !== 1'b1) $display("FAIL drop_fill_ready: got %b exp 1", fill_ready); else passed++;
      checks++; if (rd_data_a !== 16'h0) $display("FAIL drop_byp: got %h exp 0000", rd_data_a); else passed++;
      step();
      idle();
      #1;
      checks++; if (rd_data_a !== 16'h0) $display("FAIL drop_r9: got %h exp 0000", rd_data_a); else passed++;
      checks++; if (commit_cnt !== 16'd4) $display("FAIL drop_cnt: got %h exp 0004", commit_cnt); else passed++;
      wr_en = 1'b1; dst = 4'd0; wb_data = 16'hFFFF; wb_datav = 1'b1; rd_adrs_a = 4'd0;
      #1;
      checks++; if (rd_data_a !== 16'h0) $display("FAIL r0_byp: got %h exp 0000", rd_data_a); else passed++;
      step();
      wb_datav = 1'b0;
      #1;
      checks++; if (rd_pend_a !== 1'b0) $display("FAIL r0_mark_byp: got %b exp 0", rd_pend_a); else passed++;
      step();
      idle();
      #1;
      checks++; if (rd_data_a !== 16'h0) $display("FAIL r0_data: got %h exp 0000", rd_data_a); else passed++;
      checks++; if (rd_pend_a !== 1'b0) $display("FAIL r0_pend: got %b exp 0", rd_pend_a); else passed++;
      checks++; if (commit_cnt !== 16'd4) $display("FAIL r0_cnt: got %h exp 0004", commit_cnt); else passed++;
   endtask

   task automatic test_fill_mark_same();
      wr_en = 1'b1; dst = 4'd6; wb_datav = 1'b0; rd_adrs_a = 4'd6;
      step();
      fill_valid = 1'b1; fill_dst = 4'd6; fill_data = 16'h6666;
      #1;
      checks++; if (fill_ready !== 1'b1) $display("FAIL fm_fill_ready: got %b exp 1", fill_ready); else passed++;
      checks++; if (rd_pend_a !== 1'b1) $display("FAIL fm_byp_pend: got %b exp 1", rd_pend_a); else passed++;
      step();
      idle();
      #1;
      checks++; if (rd_data_a !== 16'h6666) $display("FAIL fm_data: got %h exp 6666", rd_data_a); else passed++;
      checks++; if (rd_pend_a !== 1'b1) $display("FAIL fm_pend: got %b exp 1", rd_pend_a); else passed++;
      checks++; if (commit_cnt !== 16'd5) $display("FAIL fm_cnt: got %h exp 0005", commit_cnt); else passed++;
      fill_valid = 1'b1; fill_dst = 4'd6; fill_data = 16'h1111;
      step();
      idle();
      #1;
      checks++; if (rd_data_a !== 16'h1111) $display("FAIL fm_refill: got %h exp 1111", rd_data_a); else passed++;
      checks++; if (rd_pend_a !== 1'b0) $display("FAIL fm_refill_pend: got %b exp 0", rd_pend_a); else passed++;
      checks++; if (commit_cnt !== 16'd6) $display("FAIL fm_refill_cnt: got %h exp 0006", commit_cnt); else passed++;
   endtask

   task automatic test_saturation();
      wr_en = 1'b1; dst = 4'd1; wb_data = 16'h0101; wb_datav = 1'b1;
      repeat (65528) @(posedge clock);
      #1;
      idle();
      #1;
      checks++; if (commit_cnt !== 16'hFFFE) $display("FAIL sat_preload: got %h exp fffe", commit_cnt); else passed++;
      wr_en = 1'b1; dst = 4'd2; wb_datav = 1'b0;
      step();
      wr_en = 1'b1; dst = 4'd3; wb_data = 16'h3333; wb_datav = 1'b1;
      fill_valid = 1'b1; fill_dst = 4'd2; fill_data = 16'h2222; rd_adrs_b = 4'd2;
      step();
      wr_en = 1'b0; wb_datav = 1'b0;
      #1;
      checks++; if (commit_cnt !== 16'hFFFF) $display("FAIL sat_reach: got %h exp ffff", commit_cnt); else passed++;
      step();
      idle();
      #1;
      checks++; if (commit_cnt !== 16'hFFFF) $display("FAIL sat_fill: got %h exp ffff", commit_cnt); else passed++;
      checks++; if (rd_data_b !== 16'h2222) $display("FAIL sat_r2: got %h exp 2222", rd_data_b); else passed++;
      wr_en = 1'b1; dst = 4'd8; wb_data = 16'h8888; wb_datav = 1'b1;
      step(); step();
      idle();
      #1;
      checks++; if (commit_cnt !== 16'hFFFF) $display("FAIL sat_hold: got %h exp ffff", commit_cnt); else passed++;
   endtask

   task automatic test_reset_midop();
      wr_en = 1'b1; dst = 4'd4; wb_datav = 1'b0;
      step();
      idle();
      reset = 1'b1; fill_valid = 1'b1; fill_dst = 4'd4; fill_data = 16'hABCD;
      rd_adrs_a = 4'd4; rd_adrs_b = 4'd3;
      #1;
      checks++; if (fill_ready !== 1'b0) $display("FAIL midrst_fill_ready: got %b exp 0", fill_ready); else passed++;
      step();
      idle();
      #1;
      checks++; if (rd_data_a !== 16'h0) $display("FAIL midrst_r4: got %h exp 0000", rd_data_a); else passed++;
      checks++; if (rd_pend_a !== 1'b0) $display("FAIL midrst_pend: got %b exp 0", rd_pend_a); else passed++;
      checks++; if (rd_data_b !== 16'h0) $display("FAIL midrst_r3: got %h exp 0000", rd_data_b); else passed++;
      checks++; if (commit_cnt !== 16'h0) $display("FAIL midrst_cnt: got %h exp 0000", commit_cnt); else passed++;
   endtask

   initial begin
      idle();
      rd_adrs_a = 4'd0; rd_adrs_b = 4'd0;
      #1;
      test_reset();
      test_bypass_write();
      test_pend_fill();
      test_wb_priority();
      test_drops();
      test_fill_mark_same();
      test_saturation();
      test_reset_midop();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
